fft_iter_addr_gen: RTL and testbench
====================================

// Module: fft_iter_addr_gen
// PURPOSE
//  Address generator for the iterative radix-2 DIT FFT core, directly downstream of the
//  FFT iteration control unit. Consumes its ADDR_EN / FIRST strobes and produces the
//  dual-port data-RAM read/write addresses and the twiddle-ROM address for the current
//  butterfly, walking all BUTTERFLYES butterflies of each of LAYERS layers.
// PARAMETERS
//  LAYERS       5   number of FFT layers (log2 N); also data-address width
//  BUTTERFLYES  16  butterflies per layer (N/2)
//  LayWL        3   layer-counter width, >= clog2(LAYERS)
//  ButtWL       4   butterfly-counter width, = LAYERS-1
// PORTS
//  CLK        in   1        clock, all state on rising edge
//  RST        in   1        reset: synchronous, active-high
//  EN         in   1        global enable; when low all state holds
//  START      in   1        start new transform (same pulse that starts control unit)
//  ADDR_EN    in   1        advance to next butterfly (one pulse per butterfly, in write state)
//  FIRST      in   1        first layer active: read addresses bit-reversed
//  RD_ADDR_A  out  LAYERS   RAM read address, upper butterfly input
//  RD_ADDR_B  out  LAYERS   RAM read address, lower butterfly input
//  WR_ADDR_A  out  LAYERS   RAM write address, upper butterfly output
//  WR_ADDR_B  out  LAYERS   RAM write address, lower butterfly output
//  TW_ADDR    out  ButtWL   twiddle-ROM index k of W_N^k
//  BUSY       out  1        transform in progress
//  DONE       out  1        one-cycle pulse after last butterfly of last layer
// BEHAVIOUR
//  - State: FSM {IDLE, RUN}, butt_cnt[ButtWL], lay_cnt[LayWL]. RST: IDLE, counters 0,
//    DONE 0, BUSY 0; all address outputs therefore decode to 0 (FIRST=0). RST beats START.
//  - EN low: no state change (START/ADDR_EN ignored); outputs keep decoding current state.
//  - IDLE: START&EN -> RUN, counters cleared. ADDR_EN ignored in IDLE.
//  - RUN: START&EN -> counters cleared, stay RUN (restart mid-transform; ADDR_EN same cycle
//    ignored). ADDR_EN&EN: butt_cnt+1; at BUTTERFLYES-1 wraps to 0 and lay_cnt+1; at
//    butt=BUTTERFLYES-1 and lay=LAYERS-1: counters -> 0, state -> IDLE, DONE=1 next cycle.
//  - DONE registered, high exactly one cycle; BUSY = (state==RUN).
//  - Decode (combinational from counters, zero latency), s=lay_cnt, b=butt_cnt, h=2^s:
//    addr_a = ((b>>s)<<(s+1)) | (b & (h-1));  addr_b = addr_a | h;
//    TW_ADDR = (b & (h-1)) << (LAYERS-1-s), truncated to ButtWL.
//  - WR_ADDR_A/B = addr_a/addr_b (natural order, in-place).
//  - RD_ADDR_A/B = FIRST ? bitrev(addr_a)/bitrev(addr_b) : addr_a/addr_b (bitrev over LAYERS
//    bits); FIRST is an input-driven mux, no register.
//  - Addresses valid from ADDR_EN edge of previous butterfly until next ADDR_EN edge, so
//    Wr (coincident with ADDR_EN) writes to addresses of the butterfly just computed.
//  - lay_cnt never exceeds LAYERS-1; out-of-range values unreachable.
// TESTING (LAYERS=5, BUTTERFLYES=16)
//  1 RST=1 two cycles -> all outputs 0, BUSY=0, DONE=0; ADDR_EN pulses in IDLE -> no change.
//  2 START, 3 ADDR_EN, FIRST=1 -> b=3,s=0: WR_A=6, WR_B=7, RD_A=12, RD_B=28, TW=0.
//  3 START, 37 ADDR_EN, FIRST=0 -> s=2,b=5: A=9, B=13, TW=4.
//  4 START, 80 ADDR_EN -> DONE pulse 1 cycle after 80th; on 79th: A=15,B=31,TW=15; then IDLE.
//  5 Restart: START after 20 ADDR_EN -> counters 0, BUSY stays 1; 80 more -> one DONE only.
//  6 EN=0 during ADDR_EN/START -> counters unchanged; RST with START same cycle -> IDLE.

Source files
------------

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 DIT FFT: walks butterflies of each layer
// and decodes data-RAM read/write addresses and the twiddle-ROM index from two counters.
module fft_iter_addr_gen #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              ADDR_EN,
  input  logic              FIRST,
  output logic [LAYERS-1:0] RD_ADDR_A,
  output logic [LAYERS-1:0] RD_ADDR_B,
  output logic [LAYERS-1:0] WR_ADDR_A,
  output logic [LAYERS-1:0] WR_ADDR_B,
  output logic [ButtWL-1:0] TW_ADDR,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [ButtWL-1:0] butt_cnt_q;
  logic [LayWL-1:0]  lay_cnt_q;
  logic              done_q;

  logic last_butt, last_lay;
  assign last_butt = (butt_cnt_q == ButtWL'(BUTTERFLYES - 1));
  assign last_lay  = (lay_cnt_q == LayWL'(LAYERS - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      butt_cnt_q <= '0;
      lay_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else if (EN) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q    <= RUN;
            butt_cnt_q <= '0;
            lay_cnt_q  <= '0;
          end
        end
        RUN: begin
          // START has priority: a restart discards a coincident ADDR_EN
          if (START) begin
            butt_cnt_q <= '0;
            lay_cnt_q  <= '0;
          end else if (ADDR_EN) begin
            if (last_butt) begin
              butt_cnt_q <= '0;
              if (last_lay) begin
                lay_cnt_q <= '0;
                state_q   <= IDLE;
                done_q    <= 1'b1;
              end else begin
                lay_cnt_q <= lay_cnt_q + LayWL'(1);
              end
            end else begin
              butt_cnt_q <= butt_cnt_q + ButtWL'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = done_q;

  logic [LAYERS-1:0] b_ext, h, mask, low, addr_a, addr_b, rev_a, rev_b;
  logic [LayWL-1:0]  tw_sh;

  assign b_ext = LAYERS'(butt_cnt_q);
  assign h     = LAYERS'(1) << lay_cnt_q;
  assign mask  = h - LAYERS'(1);
  assign low   = b_ext & mask;
  // Insert a zero at bit position s: group index moves up one bit, in-group offset stays
  assign addr_a = (((b_ext >> lay_cnt_q) << 1) << lay_cnt_q) | low;
  assign addr_b = addr_a | h;
  assign tw_sh  = LayWL'(LAYERS - 1) - lay_cnt_q;
  assign TW_ADDR = ButtWL'(low << tw_sh);

  always_comb begin
    rev_a = '0;
    rev_b = '0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      rev_a[i] = addr_a[LAYERS-1-i];
      rev_b[i] = addr_b[LAYERS-1-i];
    end
  end

  assign WR_ADDR_A = addr_a;
  assign WR_ADDR_B = addr_b;
  assign RD_ADDR_A = FIRST ? rev_a : addr_a;
  assign RD_ADDR_B = FIRST ? rev_b : addr_b;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Scoreboard bench for fft_iter_addr_gen: a butterfly-count model predicts every cycle's
// outputs, a monitor compares them, plus directed spot checks of known address values.
module tb_fft_iter_addr_gen;
  localparam int L  = 5;
  localparam int B  = 16;
  localparam int LW = 3;
  localparam int BW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1, EN = 1'b0, START = 1'b0, ADDR_EN = 1'b0, FIRST = 1'b0;
  logic [L-1:0]  RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
  logic [BW-1:0] TW_ADDR;
  logic BUSY, DONE;

  fft_iter_addr_gen #(.LAYERS(L), .BUTTERFLYES(B), .LayWL(LW), .ButtWL(BW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ADDR_EN(ADDR_EN), .FIRST(FIRST),
    .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .WR_ADDR_A(WR_ADDR_A),
    .WR_ADDR_B(WR_ADDR_B), .TW_ADDR(TW_ADDR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ra, rb, wa, wb, tw, busy, done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int unsigned tests = 0, fails = 0;

  // Model: transform progress is just the number of butterflies completed so far
  bit m_busy = 0, m_done = 0;
  int m_p = 0;

  function automatic int rev5(input int x);
    int r = 0;
    for (int i = 0; i < L; i++) if ((x >> i) & 1) r |= 1 << (L - 1 - i);
    return r;
  endfunction

  function automatic exp_t expect_now(input bit fst);
    exp_t e;
    int s, b, h, j, a, bb;
    s = m_p / B;
    b = m_p % B;
    h = 1 << s;
    j = b % h;
    a = (b / h) * 2 * h + j;
    bb = a + h;
    e.wa = a;
    e.wb = bb;
    e.ra = fst ? rev5(a) : a;
    e.rb = fst ? rev5(bb) : bb;
    e.tw = j * (B / h);
    e.busy = m_busy;
    e.done = m_done;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("rd_a", int'(RD_ADDR_A), mon_e.ra);
      check("rd_b", int'(RD_ADDR_B), mon_e.rb);
      check("wr_a", int'(WR_ADDR_A), mon_e.wa);
      check("wr_b", int'(WR_ADDR_B), mon_e.wb);
      check("tw",   int'(TW_ADDR),   mon_e.tw);
      check("busy", int'(BUSY),      mon_e.busy);
      check("done", int'(DONE),      mon_e.done);
    end
  end

  task automatic step(input bit rst, input bit en, input bit st, input bit aen, input bit fst);
    RST = rst; EN = en; START = st; ADDR_EN = aen; FIRST = fst;
    @(posedge CLK);
    if (rst) begin
      m_busy = 0; m_p = 0; m_done = 0;
    end else if (en) begin
      m_done = 0;
      if (st) begin
        m_busy = 1; m_p = 0;
      end else if (m_busy && aen) begin
        if (m_p == L * B - 1) begin
          m_p = 0; m_busy = 0; m_done = 1;
        end else begin
          m_p++;
        end
      end
    end
    q.push_back(expect_now(fst));
    #2;
  endtask

  int dcount;

  initial begin
    // 1: reset, then ADDR_EN pulses while idle
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_wr_a", int'(WR_ADDR_A), 0);
    check("rst_tw", int'(TW_ADDR), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
    check("idle_wr_a", int'(WR_ADDR_A), 0);
    check("idle_busy", int'(BUSY), 0);

    // 2: first layer with bit-reversed reads
    step(0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1);
    check("t2_wr_a", int'(WR_ADDR_A), 6);
    check("t2_wr_b", int'(WR_ADDR_B), 7);
    check("t2_rd_a", int'(RD_ADDR_A), 12);
    check("t2_rd_b", int'(RD_ADDR_B), 28);
    check("t2_tw", int'(TW_ADDR), 0);

    // 3: layer 2, butterfly 5
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 37; i++) step(0, 1, 0, 1, 0);
    check("t3_a", int'(WR_ADDR_A), 9);
    check("t3_b", int'(WR_ADDR_B), 13);
    check("t3_rd_a", int'(RD_ADDR_A), 9);
    check("t3_tw", int'(TW_ADDR), 4);

    // 4: full transform with interleaved idle cycles
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 79; i++) begin
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0);
    end
    check("t4_a", int'(WR_ADDR_A), 15);
    check("t4_b", int'(WR_ADDR_B), 31);
    check("t4_tw", int'(TW_ADDR), 15);
    check("t4_busy_pre", int'(BUSY), 1);
    step(0, 1, 0, 1, 0);
    check("t4_done", int'(DONE), 1);
    check("t4_busy_post", int'(BUSY), 0);
    step(0, 1, 0, 0, 0);
    check("t4_done_clr", int'(DONE), 0);

    // 5: restart mid-transform, then complete once
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    check("t5_busy", int'(BUSY), 1);
    check("t5_wr_a", int'(WR_ADDR_A), 0);
    dcount = 0;
    for (int i = 0; i < 85; i++) begin
      step(0, 1, 0, 1, 0);
      if (DONE) dcount++;
    end
    check("t5_done_count", dcount, 1);

    // 6: EN low freezes everything; RST beats START
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    check("t6_en_wr_a", int'(WR_ADDR_A), 10);
    step(1, 1, 1, 0, 0);
    check("t6_rst_busy", int'(BUSY), 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    step(0, 1, 0, 0, 0);
    #5;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
